alu_seq: RTL

Sequential, parametrised successor of the datapath ALU. It latches operands on a start handshake and executes single-cycle logic, arithmetic and rotate ops, plus an iterative multi-cycle multiply. Results and a persistent flags register are held until the next operation. It sits on the shared data bus and drives it only when addressed with REG_OP_WRITE.

---
 rtl/alu_seq_pkg.sv | 57 +++++
 rtl/alu_mul_iter.sv | 63 ++++++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   alu_op_t    - operation select (values 14 and 15 are undefined and leave
//                 state unchanged)
//   reg_op_t    - shared-bus control; only REG_OP_WRITE lets the ALU drive
//   alu_flags_t - {carry, overflow, zero, negative}
//   alu_state_t - control FSM state
//   add_ovf / sub_ovf - signed overflow from operand and result sign bits
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_OP_NOT  = 4'd0,
    ALU_OP_OR   = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_XOR  = 4'd3,
    ALU_OP_ADD  = 4'd4,
    ALU_OP_SUB  = 4'd5,
    ALU_OP_SHL  = 4'd6,
    ALU_OP_LSHR = 4'd7,
    ALU_OP_ASHR = 4'd8,
    ALU_OP_ADC  = 4'd9,
    ALU_OP_SBC  = 4'd10,
    ALU_OP_ROL  = 4'd11,
    ALU_OP_ROR  = 4'd12,
    ALU_OP_MUL  = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2
  } reg_op_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  // Two same-sign operands producing a result of the other sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Operands of differing sign where the result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - latch a/b and begin (ignored while busy)
//   a, b       - operands, WIDTH bits
//   busy       - high for exactly WIDTH cycles while iterating
//   done       - one-cycle pulse in the cycle after the last step
//   product    - 2*WIDTH-bit accumulator, final once done pulses
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        // Multiplicand walks left while the multiplier is consumed LSB first.
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arith/shift/rotate ops and
// an iterative multiply. Result and flags are registered and persist until
// the next operation.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - latch a, b, mode this cycle (ignored unless idle)
//   a, b       - operands, WIDTH bits
//   mode       - alu_op_t operation select
//   control    - reg_op_t; REG_OP_WRITE puts the result register on out
//   out        - result register or high impedance
//   busy       - high while the multiplier iterates
//   done       - one-cycle pulse after each result-register update
//   flags      - {carry, overflow, zero, negative}, always driven
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          mode,
  input  reg_op_t          control,
  output wire [WIDTH-1:0]  out,
  output logic             busy,
  output logic             done,
  output alu_flags_t       flags
);

  alu_state_t         state;
  logic [WIDTH-1:0]   result;

  logic [WIDTH-1:0]   alu_res;
  alu_flags_t         alu_flg;
  logic               op_valid;
  logic               cin;
  logic [WIDTH:0]     wide;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic               mul_hi;

  // Single-cycle operation result, computed from the live inputs and the
  // stored carry; it only reaches the outputs through the result register.
  always_comb begin
    alu_res  = '0;
    alu_flg  = '0;
    op_valid = 1'b1;
    wide     = '0;
    // ADC and SBC fold the stored carry/borrow in.
    cin      = ((mode == ALU_OP_ADC) || (mode == ALU_OP_SBC)) ? flags.carry : 1'b0;
    case (mode)
      ALU_OP_NOT: alu_res = ~a;
      ALU_OP_OR:  alu_res = a | b;
      ALU_OP_AND: alu_res = a & b;
      ALU_OP_XOR: alu_res = a ^ b;
      ALU_OP_ADD, ALU_OP_ADC: begin
        wide             = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        alu_res          = wide[WIDTH-1:0];
        alu_flg.carry    = wide[WIDTH];
        alu_flg.overflow = add_ovf(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
      end
      ALU_OP_SUB, ALU_OP_SBC: begin
        // Bit WIDTH of the zero-extended difference is the borrow.
        wide             = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        alu_res          = wide[WIDTH-1:0];
        alu_flg.carry    = wide[WIDTH];
        alu_flg.overflow = sub_ovf(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
      end
      ALU_OP_SHL: begin
        alu_res       = {a[WIDTH-2:0], 1'b0};
        alu_flg.carry = a[WIDTH-1];
      end
      ALU_OP_LSHR: begin
        alu_res       = {1'b0, a[WIDTH-1:1]};
        alu_flg.carry = a[0];
      end
      ALU_OP_ASHR: begin
        alu_res       = {a[WIDTH-1], a[WIDTH-1:1]};
        alu_flg.carry = a[0];
      end
      ALU_OP_ROL: begin
        alu_res       = {a[WIDTH-2:0], flags.carry};
        alu_flg.carry = a[WIDTH-1];
      end
      ALU_OP_ROR: begin
        alu_res       = {flags.carry, a[WIDTH-1:1]};
        alu_flg.carry = a[0];
      end
      // MUL is handled by the iterative multiplier; anything else is
      // undefined and must leave result and flags untouched.
      default: op_valid = 1'b0;
    endcase
    if (op_valid) begin
      alu_flg.zero     = (alu_res == '0);
      alu_flg.negative = alu_res[WIDTH-1];
    end else begin
      alu_res = result;
      alu_flg = flags;
    end
  end

  assign mul_start = (state == ST_IDLE) && start && (mode == ALU_OP_MUL);
  assign mul_hi    = |product[2*WIDTH-1:WIDTH];

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (mul_done),
    .product (product)
  );

  // Control FSM and result/flags registers. The FSM stays in ST_MUL until
  // the multiplier's done is seen, so a start in that last cycle is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode == ALU_OP_MUL) begin
              state <= ST_MUL;
            end else begin
              result <= alu_res;
              flags  <= alu_flg;
              done   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result         <= product[WIDTH-1:0];
            flags.carry    <= mul_hi;
            flags.overflow <= mul_hi;
            flags.zero     <= (product[WIDTH-1:0] == '0);
            flags.negative <= product[WIDTH-1];
            done           <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out = (control == REG_OP_WRITE) ? result : {WIDTH{1'bz}};

endmodule
